rot_seq16: RTL and testbench

ROT_SEQ16 -- requirements
Module: rot_seq16

---
 rtl/rot_seq16_pkg.sv | 49 ++++
 rtl/rot_seq16_dly.sv | 62 ++++++
 rtl/rot_seq16.sv | 191 +++++++++++++++++++
 tb/tb_rot_seq16.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_seq16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rot_seq16_pkg
// Purpose  : Shared definitions for the 16-point twiddle rotation sequencer:
//            multiplier-select encodings, exponent-to-code table, routing tag.
// Revision : 1.0 - initial release
// ============================================================================
package rot_seq16_pkg;

  // Selects for the shared constant multiplier (code 3 is not used)
  localparam logic [1:0] MSEL_X0541 = 2'd0;
  localparam logic [1:0] MSEL_X0707 = 2'd1;
  localparam logic [1:0] MSEL_X1307 = 2'd2;

  // Per-exponent action: multiply or bypass, which constant, and -j post-rotation.
  // e4 marks the bypass-with-(-j) case, done locally as a swap/negate.
  typedef struct packed {
    logic       mult;
    logic [1:0] msel;
    logic       mpyj;
    logic       e4;
  } code_t;

  // Routing tag carried alongside every sample in flight
  typedef struct packed {
    logic valid;
    logic bypass;
    logic e4;
  } tag_t;

  // Indexed by rotation exponent e (0..7)
  localparam code_t [7:0] CODE_TABLE = {
    {1'b1, MSEL_X1307, 1'b1, 1'b0},  // e=7
    {1'b1, MSEL_X0707, 1'b1, 1'b0},  // e=6
    {1'b1, MSEL_X0541, 1'b1, 1'b0},  // e=5
    {1'b0, MSEL_X0541, 1'b0, 1'b1},  // e=4 : bypass, -j
    {1'b1, MSEL_X1307, 1'b0, 1'b0},  // e=3
    {1'b1, MSEL_X0707, 1'b0, 1'b0},  // e=2
    {1'b1, MSEL_X0541, 1'b0, 1'b0},  // e=1
    {1'b0, MSEL_X0541, 1'b0, 1'b0}   // e=0 : bypass
  };

  // Rotation exponent (k[1:0] * k[3:2]) mod 8; a 3-bit product wraps naturally
  function automatic logic [2:0] rot_exp(input logic [3:0] k);
    return {1'b0, k[1:0]} * {1'b0, k[3:2]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rot_seq16_dly.sv
`default_nettype none
// ============================================================================
// Module   : rot_seq16_dly
// Purpose  : DEPTH-stage sample-plus-tag delay line, advancing one slot per
//            enabled cycle, so bypassed samples line up with multiplier results.
// Revision : 1.0 - initial release
// ============================================================================
module rot_seq16_dly
  import rot_seq16_pkg::*;
#(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  tag_t         i_tag,
  input  logic [W-1:0] i_data,
  output tag_t         o_tag,
  output logic [W-1:0] o_data
);

  tag_t         tag_chain  [DEPTH+1];
  logic [W-1:0] data_chain [DEPTH+1];

  assign tag_chain[0]  = i_tag;
  assign data_chain[0] = i_data;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    tag_t         tag_q,  tag_d;
    logic [W-1:0] data_q, data_d;

    // Take the previous slot only on enabled cycles, otherwise hold
    always_comb begin
      tag_d  = tag_q;
      data_d = data_q;
      if (i_en) begin
        tag_d  = tag_chain[g];
        data_d = data_chain[g];
      end
    end

    // Stage register; reset empties the slot
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tag_q  <= '0;
        data_q <= '0;
      end else begin
        tag_q  <= tag_d;
        data_q <= data_d;
      end
    end

    assign tag_chain[g+1]  = tag_q;
    assign data_chain[g+1] = data_q;
  end

  assign o_tag  = tag_chain[DEPTH];
  assign o_data = data_chain[DEPTH];

endmodule
`default_nettype wire

// File: rtl/rot_seq16.sv
`default_nettype none
// ============================================================================
// Module   : rot_seq16
// Purpose  : 16-point twiddle rotation sequencer. Indexes incoming samples,
//            sends multiply cases to a shared constant multiplier, delays
//            bypass cases to match, and re-emits samples in order LAT+1
//            enabled cycles after acceptance.
// Options  : ROT_SEQ16_FRAME_ERR_EN - enables sticky short-frame flag FERR.
// Revision : 1.0 - initial release
// ============================================================================
module rot_seq16
  import rot_seq16_pkg::*;
#(
  parameter int nb  = 12,
  parameter int LAT = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EI,
  input  logic          START,
  input  logic          ED,
  input  logic [nb-1:0] DR,
  input  logic [nb-1:0] DI,
  output logic          MED,
  output logic          MPYJ,
  output logic [1:0]    MSEL,
  output logic [nb-1:0] MDR,
  output logic [nb-1:0] MDI,
  input  logic [nb-1:0] MDOR,
  input  logic [nb-1:0] MDOI,
  output logic [nb-1:0] DOR,
  output logic [nb-1:0] DOI,
  output logic          RDY,
  output logic          FERR
);

  logic          accept;
  logic [3:0]    idx;
  code_t         code;

  logic [3:0]    k_q, k_d;
  logic          med_q, med_d;
  logic          mpyj_q, mpyj_d;
  logic [1:0]    msel_q, msel_d;
  logic [nb-1:0] mdr_q, mdr_d;
  logic [nb-1:0] mdi_q, mdi_d;
  tag_t          tag0_q, tag0_d;
  logic [nb-1:0] dor_q, dor_d;
  logic [nb-1:0] doi_q, doi_d;
  logic          rdy_q, rdy_d;

  tag_t            tag_tail;
  logic [2*nb-1:0] data_tail;
  logic [nb-1:0]   tail_r, tail_i;

  // A START sample is index 0 regardless of the running count
  assign accept = EI & ED;
  assign idx    = START ? 4'd0 : k_q;
  assign code   = CODE_TABLE[rot_exp(idx)];

  // Sample index counter: one step per accepted sample, START restarts it
  always_comb begin
    k_d = k_q;
    if (EI) begin
      if (START)   k_d = ED ? 4'd1 : 4'd0;
      else if (ED) k_d = k_q + 4'd1;
    end
  end

  // Issue stage: register the sample, fire the multiplier, tag the route
  always_comb begin
    med_d  = med_q;
    mpyj_d = mpyj_q;
    msel_d = msel_q;
    mdr_d  = mdr_q;
    mdi_d  = mdi_q;
    tag0_d = tag0_q;
    if (EI) begin
      med_d         = accept & code.mult;
      tag0_d.valid  = accept;
      tag0_d.bypass = ~code.mult;
      tag0_d.e4     = code.e4;
      if (accept) begin
        mdr_d = DR;
        mdi_d = DI;
        // Select lines only move when a new multiply is launched
        if (code.mult) begin
          msel_d = code.msel;
          mpyj_d = code.mpyj;
        end
      end
    end
  end

  // Bypass samples travel alongside their tags to meet the multiplier latency
  rot_seq16_dly #(
    .W     (2*nb),
    .DEPTH (LAT)
  ) u_dly (
    .clk    (CLK),
    .rst    (RST),
    .i_en   (EI),
    .i_tag  (tag0_q),
    .i_data ({mdr_q, mdi_q}),
    .o_tag  (tag_tail),
    .o_data (data_tail)
  );

  assign tail_r = data_tail[2*nb-1:nb];
  assign tail_i = data_tail[nb-1:0];

  // Output stage: route by the sample's own tag; hold data between strobes
  always_comb begin
    rdy_d = rdy_q;
    dor_d = dor_q;
    doi_d = doi_q;
    if (EI) begin
      rdy_d = tag_tail.valid;
      if (tag_tail.valid) begin
        if (!tag_tail.bypass) begin
          dor_d = MDOR;
          doi_d = MDOI;
        end else if (tag_tail.e4) begin
          // (r + j i) * (-j) = i - j r ; negation wraps, no saturation
          dor_d = tail_i;
          doi_d = -tail_r;
        end else begin
          dor_d = tail_r;
          doi_d = tail_i;
        end
      end
    end
  end

  // State registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      k_q    <= '0;
      med_q  <= 1'b0;
      mpyj_q <= 1'b0;
      msel_q <= '0;
      mdr_q  <= '0;
      mdi_q  <= '0;
      tag0_q <= '0;
      dor_q  <= '0;
      doi_q  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      k_q    <= k_d;
      med_q  <= med_d;
      mpyj_q <= mpyj_d;
      msel_q <= msel_d;
      mdr_q  <= mdr_d;
      mdi_q  <= mdi_d;
      tag0_q <= tag0_d;
      dor_q  <= dor_d;
      doi_q  <= doi_d;
      rdy_q  <= rdy_d;
    end
  end

`ifdef ROT_SEQ16_FRAME_ERR_EN
  logic ferr_q, ferr_d;

  // Sticky flag: a frame restarted before the previous one wrapped to 0
  always_comb begin
    ferr_d = ferr_q | (EI & START & (k_q != 4'd0));
  end

  // Short-frame flag register, cleared only by reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ferr_q <= 1'b0;
    else     ferr_q <= ferr_d;
  end

  assign FERR = ferr_q;
`else
  assign FERR = 1'b0;
`endif

  assign MED  = med_q;
  assign MPYJ = mpyj_q;
  assign MSEL = msel_q;
  assign MDR  = mdr_q;
  assign MDI  = mdi_q;
  assign DOR  = dor_q;
  assign DOI  = doi_q;
  assign RDY  = rdy_q;

endmodule
`default_nettype wire

// File: tb/tb_rot_seq16.sv
`default_nettype none
// ============================================================================
// Module   : tb_rot_seq16
// Purpose  : Self-checking bench for rot_seq16 with a latency-LAT constant
//            multiplier model attached to the MED/MDR/MDI/MDOR/MDOI port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rot_seq16;

  localparam int NB  = 12;
  localparam int LAT = 4;

  logic          CLK = 1'b0;
  logic          RST, EI, START, ED;
  logic [NB-1:0] DR, DI, MDR, MDI, MDOR, MDOI, DOR, DOI;
  logic          MED, MPYJ, RDY, FERR;
  logic [1:0]    MSEL;

  always #5 CLK = ~CLK;

  rot_seq16 #(.nb(NB), .LAT(LAT)) dut (
    .CLK(CLK), .RST(RST), .EI(EI), .START(START), .ED(ED), .DR(DR), .DI(DI),
    .MED(MED), .MPYJ(MPYJ), .MSEL(MSEL), .MDR(MDR), .MDI(MDI),
    .MDOR(MDOR), .MDOI(MDOI), .DOR(DOR), .DOI(DOI), .RDY(RDY), .FERR(FERR)
  );

  // ---------------- arithmetic shared by multiplier model and reference ----
  function automatic int coef(input int sel);
    case (sel)
      0:       return 8865;   // 0.5411 * 2^14
      1:       return 11585;  // 0.7071 * 2^14
      2:       return 21406;  // 1.3065 * 2^14
      default: return 0;
    endcase
  endfunction

  function automatic logic [NB-1:0] scale(input logic [NB-1:0] x, input int c);
    int xs, p;
    xs = $signed(x);
    p  = (xs * c) >>> 14;
    return p[NB-1:0];
  endfunction

  function automatic logic [2*NB-1:0] mul_out(input logic [NB-1:0] r, input logic [NB-1:0] i,
                                              input int sel, input bit j);
    logic [NB-1:0] pr, pi, npr;
    pr  = scale(r, coef(sel));
    pi  = scale(i, coef(sel));
    npr = -pr;
    return j ? {pi, npr} : {pr, pi};
  endfunction

  // Reference: expected output of sample index k from its twiddle exponent
  function automatic logic [2*NB-1:0] model(input int k, input logic [NB-1:0] r, input logic [NB-1:0] i);
    int e;
    logic [NB-1:0] nr;
    e  = ((k % 4) * (k / 4)) % 8;
    nr = -r;
    if (e == 0) return {r, i};
    if (e == 4) return {i, nr};
    return mul_out(r, i, (e % 4) - 1, e > 4);
  endfunction

  // ---------------- environment: shared multiplier, LAT enabled cycles ----
  logic [2*NB-1:0] mpipe [LAT];
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < LAT; i++) mpipe[i] <= '0;
    end else if (EI) begin
      mpipe[0] <= MED ? mul_out(MDR, MDI, int'(MSEL), MPYJ) : '0;
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign {MDOR, MDOI} = mpipe[LAT-1];

  // ---------------- checking ----------------------------------------------
  typedef struct { int due; logic [NB-1:0] r; logic [NB-1:0] i; } exp_t;
  exp_t          pend[$];
  logic [NB-1:0] log_r[$], log_i[$];
  int            vecs = 0, errs = 0, ecnt = 0, idx = 0;
  int            cur, e;
  bit            mult_now;
  logic          exp_med = 0, exp_mpyj = 0, exp_ferr = 0;
  logic [1:0]    exp_msel = 0;
  logic [NB-1:0] exp_mdr = 0, exp_mdi = 0, last_r = 0, last_i = 0;
  logic [2*NB-1:0] tmp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    vecs++;
    if (act !== exp_v) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  always @(posedge RST) begin
    pend.delete();
    idx = 0; exp_med = 0; exp_ferr = 0; last_r = 0; last_i = 0;
  end

  // One compare per enabled clock edge, sampled 1 time unit after the edge
  always @(posedge CLK) begin
    if (!RST && EI) begin
      ecnt++;
      cur      = START ? 0 : idx;
      e        = ((cur % 4) * (cur / 4)) % 8;
      mult_now = ED && (e % 4 != 0);
`ifdef ROT_SEQ16_FRAME_ERR_EN
      if (START && idx != 0) exp_ferr = 1'b1;
`endif
      if (START)   idx = ED ? 1 : 0;
      else if (ED) idx = (idx + 1) % 16;
      if (ED) begin
        tmp = model(cur, DR, DI);
        pend.push_back('{ecnt + LAT + 1, tmp[2*NB-1:NB], tmp[NB-1:0]});
      end
      exp_med = mult_now;
      if (mult_now) begin
        exp_mdr  = DR;
        exp_mdi  = DI;
        exp_msel = 2'((e % 4) - 1);
        exp_mpyj = (e > 4);
      end
      #1;
      while (pend.size() > 0 && pend[0].due < ecnt) begin
        chk("RDY_missing", 0, 1);
        void'(pend.pop_front());
      end
      chk("MED", MED, exp_med);
      if (exp_med) begin
        chk("MDR", MDR, exp_mdr);
        chk("MDI", MDI, exp_mdi);
        chk("MSEL", MSEL, exp_msel);
        chk("MPYJ", MPYJ, exp_mpyj);
      end
      chk("FERR", FERR, exp_ferr);
      if (pend.size() > 0 && pend[0].due == ecnt) begin
        chk("RDY", RDY, 1);
        chk("DOR", DOR, pend[0].r);
        chk("DOI", DOI, pend[0].i);
        last_r = pend[0].r;
        last_i = pend[0].i;
        log_r.push_back(DOR);
        log_i.push_back(DOI);
        void'(pend.pop_front());
      end else begin
        chk("RDY_idle", RDY, 0);
        chk("DOR_hold", DOR, last_r);
        chk("DOI_hold", DOI, last_i);
      end
    end
  end

  // ---------------- stimulus ----------------------------------------------
  bit toggle = 0;
  int base;
  logic lit_ferr;

  task automatic cyc(input logic ed, input logic st, input logic [NB-1:0] r, input logic [NB-1:0] i);
    if (toggle) begin
      @(negedge CLK); EI = 1'b0; ED = ed; START = st; DR = r; DI = i;
    end
    @(negedge CLK); EI = 1'b1; ED = ed; START = st; DR = r; DI = i;
  endtask

  task automatic send(input logic st, input logic [NB-1:0] r, input logic [NB-1:0] i);
    cyc(1'b1, st, r, i);
    cyc(1'b0, 1'b0, '0, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, '0, '0);
  endtask

  task automatic chk_log(input string nm, input int n, input logic [NB-1:0] r, input logic [NB-1:0] i);
    if (n < log_r.size()) begin
      chk({nm, "_r"}, log_r[n], r);
      chk({nm, "_i"}, log_i[n], i);
    end else begin
      chk({nm, "_present"}, 0, 1);
    end
  endtask

  initial begin
    RST = 1'b1; EI = 1'b0; START = 1'b0; ED = 1'b0; DR = '0; DI = '0;
    repeat (2) @(negedge CLK);
    chk("rst_RDY", RDY, 0);   chk("rst_DOR", DOR, 0);  chk("rst_DOI", DOI, 0);
    chk("rst_MED", MED, 0);   chk("rst_MSEL", MSEL, 0); chk("rst_FERR", FERR, 0);
    RST = 1'b0; EI = 1'b1;

    // Frame A: ramp DR=k, DI=0, one sample every other cycle
    base = log_r.size();
    for (int k = 0; k < 16; k++) send(k == 0, NB'(k), '0);
    idle(8);
    chk("A_count", log_r.size() - base, 16);
    chk_log("A_k5",  base + 5,  NB'(2),  NB'(0));
    chk_log("A_k6",  base + 6,  NB'(4),  NB'(0));
    chk_log("A_k7",  base + 7,  NB'(9),  NB'(0));
    chk_log("A_k10", base + 10, NB'(0),  NB'(-10));
    chk_log("A_k11", base + 11, NB'(0),  NB'(-7));
    chk_log("A_k15", base + 15, NB'(8),  NB'(0));

    // Frame B: same ramp with EI alternating 0/1
    toggle = 1;
    base = log_r.size();
    for (int k = 0; k < 16; k++) send(k == 0, NB'(k), '0);
    idle(8);
    toggle = 0;
    chk("B_count", log_r.size() - base, 16);
    chk_log("B_k7",  base + 7,  NB'(9), NB'(0));
    chk_log("B_k11", base + 11, NB'(0), NB'(-7));

    // Frame C: varied data, e=4 bypass at k=10 with (100,-7)
    base = log_r.size();
    for (int k = 0; k < 16; k++) begin
      if (k == 10) send(1'b0, NB'(100), NB'(-7));
      else         send(k == 0, NB'(k * 211 - 1500), NB'(700 - k * 93));
    end
    idle(8);
    chk_log("C_k10", base + 10, NB'(-7), NB'(-100));

    // Frame D: restart after 7 samples, then k=10 with the most negative DR
    base = log_r.size();
    for (int k = 0; k < 7; k++) send(k == 0, NB'(k + 50), NB'(-k));
    send(1'b1, NB'(300), NB'(-300));
    for (int k = 1; k <= 10; k++) begin
      if (k == 10) send(1'b0, NB'(-2048), NB'(5));
      else         send(1'b0, NB'(k * 17), NB'(k * 3));
    end
    idle(8);
    chk("D_count", log_r.size() - base, 18);
    chk_log("D_inflight6", base + 6,  NB'(39),  NB'(-5));
    chk_log("D_restart0",  base + 7,  NB'(300), NB'(-300));
    chk_log("D_wrap",      base + 17, NB'(5),   NB'(-2048));
`ifdef ROT_SEQ16_FRAME_ERR_EN
    lit_ferr = 1'b1;
`else
    lit_ferr = 1'b0;
`endif
    chk("D_FERR", FERR, lit_ferr);

    // Frame E: reset two cycles after accepting k=6
    for (int k = 0; k < 7; k++) send(k == 0, NB'(k * 10 + 1), NB'(k));
    @(posedge CLK); @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("arst_RDY", RDY, 0);  chk("arst_DOR", DOR, 0);   chk("arst_DOI", DOI, 0);
    chk("arst_MED", MED, 0);  chk("arst_MPYJ", MPYJ, 0); chk("arst_MSEL", MSEL, 0);
    chk("arst_MDR", MDR, 0);  chk("arst_MDI", MDI, 0);   chk("arst_FERR", FERR, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0; EI = 1'b1; ED = 1'b0; START = 1'b0;
    base = log_r.size();
    idle(10);
    chk("E_no_rdy", log_r.size() - base, 0);

    // Frame F: fresh frame after reset
    base = log_r.size();
    for (int k = 0; k < 6; k++) send(k == 0, NB'(k + 1), '0);
    idle(8);
    chk("F_count", log_r.size() - base, 6);
    chk_log("F_k5", base + 5, NB'(3), NB'(0));

    chk("pending_empty", pend.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
